// File: rtl/operand_fetch_if.sv
// Handshake and data bundle between decode, the register file read port,
// writeback snooping and execute, as seen by the operand fetch block.
interface operand_fetch_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int SW   = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_rs1;
  logic [AW-1:0]   in_rs2;
  logic [AW-1:0]   in_rd;
  logic [AW-1:0]   rf_addr_rs1;
  logic [AW-1:0]   rf_addr_rs2;
  logic [XLEN-1:0] rf_data_rs1;
  logic [XLEN-1:0] rf_data_rs2;
  logic            wb_enable;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [AW-1:0]   out_rd;
  logic [SW-1:0]   stall_count;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, rf_data_rs1, rf_data_rs2,
           wb_enable, wb_addr, wb_data, out_ready,
    input  in_ready, rf_addr_rs1, rf_addr_rs2, out_valid,
           out_rs1_data, out_rs2_data, out_rd, stall_count
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, rf_data_rs1, rf_data_rs2,
           wb_enable, wb_addr, wb_data, out_ready,
    output in_ready, rf_addr_rs1, rf_addr_rs2, out_valid,
           out_rs1_data, out_rs2_data, out_rd, stall_count
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: drives register file reads, retries reads blocked by writes,
// bypasses in-flight writebacks and holds coherent operands for execute.
module operand_fetch #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int SW   = 16
) (
  input logic           clock,
  input logic           reset,
  operand_fetch_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DATA, S_OUT} state_t;

  state_t          r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [AW-1:0]   r_rs1;
  logic [AW-1:0]   r_rs2;
  logic [AW-1:0]   r_rd;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [SW-1:0]   r_stall;
  logic            w_eff;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (&v) ? v : v + SW'(1);
  endfunction

  // x0 reads as zero; a same-cycle effective write to rs wins over the read port.
  function automatic logic [XLEN-1:0] select_op(
    input logic [AW-1:0]   rs,
    input logic            eff,
    input logic [AW-1:0]   waddr,
    input logic [XLEN-1:0] wdata,
    input logic [XLEN-1:0] rdata
  );
    if (rs == '0)                 return '0;
    else if (eff && waddr == rs)  return wdata;
    else                          return rdata;
  endfunction

  assign w_eff = bus.wb_enable && (bus.wb_addr != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_stall     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_rs1      <= bus.in_rs1;
            r_rs2      <= bus.in_rs2;
            r_rd       <= bus.in_rd;
            r_in_ready <= 1'b0;
            r_state    <= S_READ;
          end
        end
        // Register file ignores reads while it is writing, so retry.
        S_READ: begin
          if (w_eff) r_stall <= sat_inc(r_stall);
          else       r_state <= S_DATA;
        end
        S_DATA: begin
          r_op1       <= select_op(r_rs1, w_eff, bus.wb_addr, bus.wb_data, bus.rf_data_rs1);
          r_op2       <= select_op(r_rs2, w_eff, bus.wb_addr, bus.wb_data, bus.rf_data_rs2);
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (w_eff && bus.wb_addr == r_rs1 && r_rs1 != '0) r_op1 <= bus.wb_data;
          if (w_eff && bus.wb_addr == r_rs2 && r_rs2 != '0) r_op2 <= bus.wb_data;
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.rf_addr_rs1  = r_rs1;
  assign bus.rf_addr_rs2  = r_rs2;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_rs1_data = r_op1;
  assign bus.out_rs2_data = r_op2;
  assign bus.out_rd       = r_rd;
  assign bus.stall_count  = r_stall;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural 32x32 register file
// (synchronous read, write-over-read) attached to its read port.
module tb_operand_fetch;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int SW   = 16;

  logic clock = 1'b0;
  logic reset;
  logic rf_clr;
  always #5 clock = ~clock;

  operand_fetch_if #(.XLEN(XLEN), .AW(AW), .SW(SW)) bus ();
  operand_fetch #(.XLEN(XLEN), .AW(AW), .SW(SW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [XLEN-1:0] rf [32];
  logic [XLEN-1:0] rd1, rd2;

  always @(posedge clock) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.wb_enable && bus.wb_addr != '0) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end else begin
      rd1 <= rf[bus.rf_addr_rs1];
      rd2 <= rf[bus.rf_addr_rs2];
    end
  end
  assign bus.rf_data_rs1 = rd1;
  assign bus.rf_data_rs2 = rd2;

  int total = 0;
  int bad   = 0;
  int lat;

  typedef struct {
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] e1;
    logic [XLEN-1:0] e2;
  } vec_t;
  vec_t tbl [5];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    bus.wb_enable = 1'b1;
    bus.wb_addr   = a;
    bus.wb_data   = d;
    tick();
    bus.wb_enable = 1'b0;
  endtask

  // Returns one cycle after the accepting edge, i.e. in the first READ cycle.
  task automatic issue(input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic [AW-1:0] d);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_rs1   = r1;
    bus.in_rs2   = r2;
    bus.in_rd    = d;
    tick();
    bus.in_valid = 1'b0;
    chk("in_ready_busy", bus.in_ready, 0);
  endtask

  task automatic wait_out(input int start, output int l);
    l = start;
    while (!bus.out_valid && l < 40) begin
      tick();
      l++;
    end
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("out_valid_drop", bus.out_valid, 0);
    chk("in_ready_back", bus.in_ready, 1);
  endtask

  initial begin
    bus.in_valid = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rd = 0;
    bus.wb_enable = 0; bus.wb_addr = 0; bus.wb_data = 0; bus.out_ready = 0;
    reset = 1'b1; rf_clr = 1'b1;
    tick(); tick();
    reset = 1'b0; rf_clr = 1'b0;

    tbl[0] = '{rs1: 5'd5,  rs2: 5'd6, rd: 5'd7,  e1: 32'h1234,     e2: 32'hABCD};
    tbl[1] = '{rs1: 5'd1,  rs2: 5'd2, rd: 5'd8,  e1: 32'h11111111, e2: 32'h22222222};
    tbl[2] = '{rs1: 5'd31, rs2: 5'd0, rd: 5'd31, e1: 32'hFFFFFFFF, e2: 32'h0};
    tbl[3] = '{rs1: 5'd0,  rs2: 5'd3, rd: 5'd1,  e1: 32'h0,        e2: 32'h3};
    tbl[4] = '{rs1: 5'd2,  rs2: 5'd2, rd: 5'd0,  e1: 32'h22222222, e2: 32'h22222222};

    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_rf_addr1", bus.rf_addr_rs1, 0);
    chk("rst_rf_addr2", bus.rf_addr_rs2, 0);
    chk("rst_stall", bus.stall_count, 0);

    wr(5'd5, 32'h1234); wr(5'd6, 32'hABCD); wr(5'd1, 32'h11111111);
    wr(5'd2, 32'h22222222); wr(5'd3, 32'h3); wr(5'd31, 32'hFFFFFFFF);
    tick();

    // Plain requests with no writeback traffic.
    for (int i = 0; i < 5; i++) begin
      issue(tbl[i].rs1, tbl[i].rs2, tbl[i].rd);
      chk("rf_addr1", bus.rf_addr_rs1, tbl[i].rs1);
      chk("rf_addr2", bus.rf_addr_rs2, tbl[i].rs2);
      wait_out(1, lat);
      chk("tbl_latency", lat, 3);
      chk("tbl_op1", bus.out_rs1_data, tbl[i].e1);
      chk("tbl_op2", bus.out_rs2_data, tbl[i].e2);
      chk("tbl_rd", bus.out_rd, tbl[i].rd);
      accept();
    end
    chk("stall_none", bus.stall_count, 0);

    // Two suppressed reads from a write to x9.
    issue(5'd5, 5'd6, 5'd7);
    bus.wb_enable = 1; bus.wb_addr = 5'd9; bus.wb_data = 32'h99;
    tick(); tick();
    bus.wb_enable = 0;
    wait_out(3, lat);
    chk("stall_latency", lat, 5);
    chk("stall_count2", bus.stall_count, 2);
    chk("stall_op1", bus.out_rs1_data, 32'h1234);
    accept();

    // Writes to x0 neither stall nor bypass.
    issue(5'd5, 5'd6, 5'd7);
    bus.wb_enable = 1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFF;
    tick();
    wait_out(2, lat);
    bus.wb_enable = 0;
    chk("x0_latency", lat, 3);
    chk("x0_stall", bus.stall_count, 2);
    chk("x0_op1", bus.out_rs1_data, 32'h1234);
    accept();

    // Bypass in DATA to both operands naming x5.
    issue(5'd5, 5'd5, 5'd1);
    tick();
    bus.wb_enable = 1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEAD;
    tick();
    bus.wb_enable = 0;
    chk("byp_valid", bus.out_valid, 1);
    chk("byp_op1", bus.out_rs1_data, 32'hDEAD);
    chk("byp_op2", bus.out_rs2_data, 32'hDEAD);
    accept();

    issue(5'd0, 5'd0, 5'd2);
    bus.wb_enable = 1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFF;
    wait_out(1, lat);
    bus.wb_enable = 0;
    chk("zero_latency", lat, 3);
    chk("zero_op1", bus.out_rs1_data, 0);
    chk("zero_op2", bus.out_rs2_data, 0);
    accept();

    // Held operands track writes while execute is not ready.
    issue(5'd5, 5'd6, 5'd3);
    wait_out(1, lat);
    chk("hold_latency", lat, 3);
    bus.wb_enable = 1; bus.wb_addr = 5'd6; bus.wb_data = 32'h5555;
    tick();
    bus.wb_enable = 0;
    chk("hold_op2", bus.out_rs2_data, 32'h5555);
    chk("hold_op1", bus.out_rs1_data, 32'hDEAD);
    tick(); tick();
    chk("hold_valid", bus.out_valid, 1);
    chk("hold_rd", bus.out_rd, 3);
    bus.wb_enable = 1; bus.wb_addr = 5'd5; bus.wb_data = 32'h7777;
    chk("accept_pre_edge", bus.out_rs1_data, 32'hDEAD);
    accept();
    bus.wb_enable = 0;

    // Reset during READ.
    issue(5'd5, 5'd6, 5'd4);
    reset = 1; tick(); reset = 0;
    chk("rstR_valid", bus.out_valid, 0);
    chk("rstR_ready", bus.in_ready, 1);
    chk("rstR_stall", bus.stall_count, 0);
    chk("rstR_addr", bus.rf_addr_rs1, 0);
    issue(5'd5, 5'd6, 5'd4);
    wait_out(1, lat);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_op1", bus.out_rs1_data, 32'h7777);
    chk("post_rst_op2", bus.out_rs2_data, 32'h5555);
    accept();

    // Reset during OUT, with a stall recorded first.
    issue(5'd6, 5'd5, 5'd4);
    bus.wb_enable = 1; bus.wb_addr = 5'd9; bus.wb_data = 32'h1;
    tick();
    bus.wb_enable = 0;
    wait_out(2, lat);
    chk("stall_count1", bus.stall_count, 1);
    reset = 1; tick(); reset = 0;
    chk("rstO_valid", bus.out_valid, 0);
    chk("rstO_ready", bus.in_ready, 1);
    chk("rstO_stall", bus.stall_count, 0);
    chk("rstO_op1", bus.out_rs1_data, 0);
    issue(5'd6, 5'd5, 5'd9);
    wait_out(1, lat);
    chk("rstO_new_op1", bus.out_rs1_data, 32'h5555);
    chk("rstO_new_op2", bus.out_rs2_data, 32'h7777);
    chk("rstO_new_rd", bus.out_rd, 9);
    accept();

    // Saturation of the stall counter.
    issue(5'd1, 5'd1, 5'd0);
    bus.wb_enable = 1; bus.wb_addr = 5'd9; bus.wb_data = 32'h2;
    for (int i = 0; i < 65535; i++) tick();
    chk("sat_reach", bus.stall_count, 16'hFFFF);
    for (int i = 0; i < 4; i++) tick();
    chk("sat_hold", bus.stall_count, 16'hFFFF);
    bus.wb_enable = 0;
    wait_out(0, lat);
    chk("sat_valid", bus.out_valid, 1);
    chk("sat_op1", bus.out_rs1_data, 32'h11111111);
    accept();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
